// File: rtl/video_line_doubler.sv
// Line doubler for a PPU-rate RGB stream: two-bank line buffer replayed twice under a
// frame-locked VGA timing generator. Optional VIDEO_SCANLINE_EN darkens odd output lines.
module video_line_doubler #(
    parameter int unsigned IN_W         = 5,
    parameter int unsigned OUT_W        = 4,
    parameter int unsigned SRC_W        = 256,
    parameter int unsigned H_ACTIVE     = 512,
    parameter int unsigned H_TOTAL      = 682,
    parameter int unsigned H_SYNC_START = 570,
    parameter int unsigned H_SYNC_LEN   = 82,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_TOTAL      = 524,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_LEN   = 2,
    parameter bit          SYNC_POL     = 1'b0,
    parameter int unsigned MASK_L       = 20,
    parameter int unsigned MASK_R       = 16,
    parameter int unsigned MASK_T       = 12,
    parameter int unsigned MASK_B       = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [3*IN_W-1:0] in_rgb,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              scanlines,
    input  logic              overscan,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [OUT_W-1:0]  vga_r,
    output logic [OUT_W-1:0]  vga_g,
    output logic [OUT_W-1:0]  vga_b,
    output logic              frame_lock
);

    localparam int unsigned AW    = $clog2(SRC_W);
    localparam int unsigned AW1   = AW + 1;
    localparam int unsigned HW    = $clog2(H_TOTAL);
    localparam int unsigned VW    = $clog2(V_TOTAL);
    localparam int unsigned PW    = 3 * IN_W;
    localparam int unsigned DEPTH = 2 * SRC_W;

    localparam logic [AW:0]   SrcW       = AW1'(SRC_W);
    localparam logic [HW-1:0] HLast      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HActive    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HSyncStart = HW'(H_SYNC_START);
    localparam logic [HW-1:0] HSyncEnd   = HW'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [HW-1:0] MaskL      = HW'(MASK_L);
    localparam logic [HW-1:0] MaskR      = HW'(H_ACTIVE - MASK_R);
    localparam logic [VW-1:0] VLast      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VActive    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VSyncStart = VW'(V_SYNC_START);
    localparam logic [VW-1:0] VSyncEnd   = VW'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [VW-1:0] MaskT      = VW'(MASK_T);
    localparam logic [VW-1:0] MaskB      = VW'(V_ACTIVE - MASK_B);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          lock_q, lock_d;

    logic          wr_bank_q, wr_bank_d;
    logic [AW:0]   wr_addr_q, wr_addr_d, wr_base, wr_idx;
    logic          wr_en;
    logic          rd_bank_q, rd_bank_d;
    logic [AW:0]   rd_addr, rd_idx;

    logic [PW-1:0] mem [DEPTH];
    logic [PW-1:0] pix_q;

    logic          act_h, act_v, hs_on, vs_on, border;
    logic          de1_q, hs1_q, vs1_q, mask1_q;
    logic [OUT_W-1:0] r_d, g_d, b_d;
    logic [IN_W-1:0]  cr, cg, cb;

    // MSB-first replication: truncates when narrowing, repeats MSBs into LSBs when widening.
    function automatic logic [OUT_W-1:0] conv(input logic [IN_W-1:0] c);
        logic [OUT_W-1:0] o;
        o = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            o[int'(OUT_W) - 1 - i] = c[int'(IN_W) - 1 - (i % int'(IN_W))];
        end
        return o;
    endfunction

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        lock_d = lock_q;
        if (in_vsync) begin
            h_d    = '0;
            v_d    = '0;
            lock_d = 1'b1;
        end else if (h_q == HLast) begin
            h_d = '0;
            if (v_q == VLast) begin
                v_d    = '0;
                lock_d = 1'b0;
            end else begin
                v_d = v_q + 1'b1;
            end
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    // A pixel arriving with in_hsync already belongs to the new bank at address 0.
    always_comb begin
        wr_bank_d = in_hsync ? ~wr_bank_q : wr_bank_q;
        wr_base   = in_hsync ? '0 : wr_addr_q;
        wr_en     = in_valid && (wr_base < SrcW);
        wr_addr_d = wr_en ? wr_base + 1'b1 : wr_base;
        wr_idx    = wr_bank_d ? SrcW + wr_base : wr_base;
    end

    // Latch is visible in the h==0 read itself so the first pixel of the pair uses the new bank.
    always_comb begin
        act_h     = h_q < HActive;
        act_v     = v_q < VActive;
        rd_bank_d = (h_q == '0 && !v_q[0]) ? ~wr_bank_q : rd_bank_q;
        rd_addr   = act_h ? AW1'(h_q >> 1) : '0;
        rd_idx    = rd_bank_d ? SrcW + rd_addr : rd_addr;
        hs_on     = (h_q >= HSyncStart) && (h_q < HSyncEnd);
        vs_on     = (v_q >= VSyncStart) && (v_q < VSyncEnd);
        border    = (h_q < MaskL) || (h_q >= MaskR) || (v_q < MaskT) || (v_q >= MaskB);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q       <= '0;
            v_q       <= '0;
            lock_q    <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            lock_q    <= lock_d;
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Line buffer storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= in_rgb;
        end
        pix_q <= mem[rd_idx];
    end

`ifdef VIDEO_SCANLINE_EN
    logic dim1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dim1_q <= 1'b0;
        end else begin
            dim1_q <= scanlines && v_q[0];
        end
    end
`else
    logic unused_scanlines;
    assign unused_scanlines = scanlines;
`endif

    // First stage: control delayed alongside the registered buffer read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de1_q   <= 1'b0;
            hs1_q   <= ~SYNC_POL;
            vs1_q   <= ~SYNC_POL;
            mask1_q <= 1'b0;
        end else begin
            de1_q   <= act_h && act_v;
            hs1_q   <= hs_on ? SYNC_POL : ~SYNC_POL;
            vs1_q   <= vs_on ? SYNC_POL : ~SYNC_POL;
            mask1_q <= overscan && border;
        end
    end

    always_comb begin
        cr = pix_q[IN_W-1:0];
        cg = pix_q[2*IN_W-1:IN_W];
        cb = pix_q[PW-1:2*IN_W];
`ifdef VIDEO_SCANLINE_EN
        if (dim1_q) begin
            cr = cr >> 1;
            cg = cg >> 1;
            cb = cb >> 1;
        end
`endif
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (de1_q && !mask1_q) begin
            r_d = conv(cr);
            g_d = conv(cg);
            b_d = conv(cb);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
            vga_de <= 1'b0;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_hs <= hs1_q;
            vga_vs <= vs1_q;
            vga_de <= de1_q;
            vga_r  <= r_d;
            vga_g  <= g_d;
            vga_b  <= b_d;
        end
    end

    assign frame_lock = lock_q;

endmodule

// File: tb/tb_video_line_doubler.sv
// Directed bench for video_line_doubler; a short vertical frame keeps full-frame scenarios cheap.
module tb_video_line_doubler;

    localparam int H_TOTAL      = 682;
    localparam int V_TOTAL      = 32;
    localparam int V_ACTIVE     = 28;
    localparam int V_SYNC_START = 29;
    localparam int V_SYNC_LEN   = 2;
    localparam int MASK_T       = 12;
    localparam int MASK_B       = 8;
    localparam int BOUND        = 50000;

`ifdef VIDEO_SCANLINE_EN
    localparam logic [11:0] ODD_EXP = 12'h777;
`else
    localparam logic [11:0] ODD_EXP = 12'hFFF;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [14:0] in_rgb = '0;
    logic        in_hsync = 1'b0;
    logic        in_vsync = 1'b0;
    logic        scanlines = 1'b0;
    logic        overscan = 1'b0;
    logic        vga_hs, vga_vs, vga_de, frame_lock;
    logic [3:0]  vga_r, vga_g, vga_b;

    int errors = 0;
    int checks = 0;
    // Counter position (bh,bv) and the position currently on the pins (h2,v2).
    int bh, bv, h1, v1, h2, v2;

    video_line_doubler #(
        .V_ACTIVE     (V_ACTIVE),
        .V_TOTAL      (V_TOTAL),
        .V_SYNC_START (V_SYNC_START),
        .V_SYNC_LEN   (V_SYNC_LEN),
        .MASK_T       (MASK_T),
        .MASK_B       (MASK_B)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_rgb     (in_rgb),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .scanlines  (scanlines),
        .overscan   (overscan),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_de     (vga_de),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .frame_lock (frame_lock)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        bh = 0; bv = 0; h1 = -1; v1 = -1; h2 = -1; v2 = -1;
    endtask

    task automatic step();
        logic vs_s;
        vs_s = in_vsync;
        @(posedge clk);
        #1;
        h2 = h1; v2 = v1; h1 = bh; v1 = bv;
        if (vs_s) begin
            bh = 0; bv = 0;
        end else if (bh == H_TOTAL - 1) begin
            bh = 0;
            bv = (bv == V_TOTAL - 1) ? 0 : bv + 1;
        end else begin
            bh++;
        end
    endtask

    task automatic goto_pin(input int hh, input int vv);
        int n;
        n = 0;
        while (!(h2 == hh && v2 == vv) && n < BOUND) begin
            step();
            n++;
        end
        if (!(h2 == hh && v2 == vv)) begin
            checks++; errors++;
            $display("FAIL goto_pin timeout: at h=%0d v=%0d, wanted h=%0d v=%0d", h2, v2, hh, vv);
        end
    endtask

    task automatic goto_cnt(input int hh, input int vv);
        int n;
        n = 0;
        while (!(bh == hh && bv == vv) && n < BOUND) begin
            step();
            n++;
        end
        if (!(bh == hh && bv == vv)) begin
            checks++; errors++;
            $display("FAIL goto_cnt timeout: at h=%0d v=%0d, wanted h=%0d v=%0d", bh, bv, hh, vv);
        end
    endtask

    function automatic logic [14:0] pix(input int k);
        logic [4:0] n;
        n = k[4:0];
        return {n ^ 5'h0A, ~n, n};
    endfunction

    // Expected {r,g,b}: top four bits of each 5-bit channel.
    function automatic logic [11:0] pix_exp(input int k);
        logic [14:0] p;
        p = pix(k);
        return {p[4:1], p[9:6], p[14:11]};
    endfunction

    task automatic pulse_vsync();
        in_vsync = 1'b1;
        step();
        in_vsync = 1'b0;
    endtask

    // hsync with pixel 0, 260 pixels (last four beyond SRC_W), closing hsync.
    task automatic fill_line(input bit pattern, input logic [14:0] val);
        for (int i = 0; i < 260; i++) begin
            in_valid = 1'b1;
            in_hsync = (i == 0);
            if (pattern) in_rgb = (i < 256) ? pix(i) : 15'h56B5;
            else         in_rgb = val;
            step();
        end
        in_valid = 1'b0;
        in_hsync = 1'b1;
        step();
        in_hsync = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_hs, exp_de;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL rst_de: got %b expected 0", vga_de); end
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            errors++; $display("FAIL rst_rgb: got %h expected 000", {vga_r, vga_g, vga_b});
        end
        checks++; if (vga_hs !== 1'b1) begin errors++; $display("FAIL rst_hs: got %b expected 1", vga_hs); end
        checks++; if (vga_vs !== 1'b1) begin errors++; $display("FAIL rst_vs: got %b expected 1", vga_vs); end
        checks++; if (frame_lock !== 1'b0) begin errors++; $display("FAIL rst_lock: got %b expected 0", frame_lock); end
        reset_n = 1'b1;
        model_reset();
        for (int k = 1; k <= H_TOTAL; k++) begin
            step();
            exp_hs = (h2 >= 570 && h2 < 652) ? 1'b0 : 1'b1;
            exp_de = (h2 >= 0 && h2 < 512);
            checks++;
            if (vga_hs !== exp_hs) begin
                errors++; $display("FAIL free_hs cycle %0d: got %b expected %b", k, vga_hs, exp_hs);
            end
            checks++;
            if (vga_de !== exp_de) begin
                errors++; $display("FAIL free_de cycle %0d: got %b expected %b", k, vga_de, exp_de);
            end
            if (!exp_de) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== 12'h000) begin
                    errors++; $display("FAIL free_rgb cycle %0d: got %h expected 000", k, {vga_r, vga_g, vga_b});
                end
            end
        end
        checks++; if (vga_vs !== 1'b1) begin errors++; $display("FAIL free_vs: got %b expected 1", vga_vs); end
        checks++; if (frame_lock !== 1'b0) begin errors++; $display("FAIL free_lock: got %b expected 0", frame_lock); end
    endtask

    task automatic test_line_double();
        int ks[4];
        ks = '{0, 5, 31, 255};
        checks++; if (frame_lock !== 1'b0) begin errors++; $display("FAIL lock_pre: got %b expected 0", frame_lock); end
        pulse_vsync();
        checks++; if (frame_lock !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b expected 1", frame_lock); end
        fill_line(1'b1, '0);
        goto_pin(0, 2);
        checks++; if (vga_de !== 1'b1) begin errors++; $display("FAIL dbl_de: got %b expected 1", vga_de); end
        for (int vv = 2; vv <= 3; vv++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 2; j++) begin
                    goto_pin(2 * ks[i] + j, vv);
                    checks++;
                    if ({vga_r, vga_g, vga_b} !== pix_exp(ks[i])) begin
                        errors++;
                        $display("FAIL dbl_rgb h=%0d v=%0d: got %h expected %h",
                                 2 * ks[i] + j, vv, {vga_r, vga_g, vga_b}, pix_exp(ks[i]));
                    end
                end
            end
        end
        goto_pin(512, 3);
        checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL dbl_blank_de: got %b expected 0", vga_de); end
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            errors++; $display("FAIL dbl_blank_rgb: got %h expected 000", {vga_r, vga_g, vga_b});
        end
    endtask

    task automatic test_overscan();
        int          ph[8];
        int          pv[8];
        logic [11:0] pe[8];
        ph = '{100, 100, 19, 20, 495, 496, 100, 100};
        pv = '{11, 12, 14, 14, 14, 14, 19, 20};
        pe = '{12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 12'h000};
        overscan = 1'b1;
        pulse_vsync();
        fill_line(1'b0, 15'h7FFF);
        for (int i = 0; i < 8; i++) begin
            goto_pin(ph[i], pv[i]);
            checks++;
            if ({vga_r, vga_g, vga_b} !== pe[i]) begin
                errors++;
                $display("FAIL ovs_rgb h=%0d v=%0d: got %h expected %h",
                         ph[i], pv[i], {vga_r, vga_g, vga_b}, pe[i]);
            end
            checks++;
            if (vga_de !== 1'b1) begin
                errors++; $display("FAIL ovs_de h=%0d v=%0d: got %b expected 1", ph[i], pv[i], vga_de);
            end
        end
        overscan = 1'b0;
    endtask

    task automatic test_scanlines();
        scanlines = 1'b1;
        pulse_vsync();
        fill_line(1'b0, 15'h7BDE);
        goto_pin(100, 2);
        checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin
            errors++; $display("FAIL scan_even: got %h expected FFF", {vga_r, vga_g, vga_b});
        end
        goto_pin(100, 3);
        checks++; if ({vga_r, vga_g, vga_b} !== ODD_EXP) begin
            errors++; $display("FAIL scan_odd: got %h expected %h", {vga_r, vga_g, vga_b}, ODD_EXP);
        end
        goto_pin(100, 4);
        checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin
            errors++; $display("FAIL scan_even2: got %h expected FFF", {vga_r, vga_g, vga_b});
        end
        scanlines = 1'b0;
    endtask

    task automatic test_vsync_midline();
        int          vh[4];
        int          vvs[4];
        logic        ve[4];
        vh  = '{0, 0, 681, 0};
        vvs = '{28, 29, 30, 31};
        ve  = '{1'b1, 1'b0, 1'b0, 1'b1};
        goto_cnt(300, 5);
        pulse_vsync();
        checks++; if (frame_lock !== 1'b1) begin errors++; $display("FAIL mid_lock: got %b expected 1", frame_lock); end
        for (int i = 0; i < 4; i++) begin
            goto_pin(vh[i], vvs[i]);
            checks++;
            if (vga_vs !== ve[i]) begin
                errors++; $display("FAIL mid_vs h=%0d v=%0d: got %b expected %b", vh[i], vvs[i], vga_vs, ve[i]);
            end
        end
        goto_cnt(681, 31);
        checks++; if (frame_lock !== 1'b1) begin errors++; $display("FAIL lock_hold: got %b expected 1", frame_lock); end
        step();
        checks++; if (frame_lock !== 1'b0) begin errors++; $display("FAIL lock_fall: got %b expected 0", frame_lock); end
    endtask

    task automatic test_mid_reset();
        pulse_vsync();
        checks++; if (frame_lock !== 1'b1) begin errors++; $display("FAIL mr_lock_pre: got %b expected 1", frame_lock); end
        goto_cnt(580, 3);
        reset_n = 1'b0;
        #2;
        checks++; if (frame_lock !== 1'b0) begin errors++; $display("FAIL mr_lock: got %b expected 0", frame_lock); end
        checks++; if (vga_hs !== 1'b1) begin errors++; $display("FAIL mr_hs: got %b expected 1", vga_hs); end
        checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL mr_de: got %b expected 0", vga_de); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        goto_pin(0, 0);
        checks++; if (vga_de !== 1'b1) begin errors++; $display("FAIL mr_de_h0: got %b expected 1", vga_de); end
        goto_pin(512, 0);
        checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL mr_de_h512: got %b expected 0", vga_de); end
        goto_pin(570, 0);
        checks++; if (vga_hs !== 1'b0) begin errors++; $display("FAIL mr_hs_h570: got %b expected 0", vga_hs); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_line_double();
        test_overscan();
        test_scanlines();
        test_vsync_midline();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
